// File: rtl/mips_dbus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_dbus_pkg                                                |
// | Description : Shared definitions for the mips_dbus data-side bus target:   |
// |               I/O register offsets, STATUS bit positions and a helper      |
// |               that packs the STATUS read word.                             |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mips_dbus_pkg;

  // I/O register select, taken from DA[3:2] inside the I/O window.
  typedef enum logic [1:0] {
    IO_TXDATA = 2'd0,
    IO_STATUS = 2'd1,
    IO_CYCLE  = 2'd2,
    IO_RSVD   = 2'd3
  } io_reg_e;

  // STATUS bit positions.
  localparam int c_ST_EMPTY     = 0;
  localparam int c_ST_FULL      = 1;
  localparam int c_ST_OVF       = 2;
  localparam int c_ST_COUNT_LSB = 4;

  // STATUS read word: {24'b0, count[3:0], 1'b0, ovf, full, empty}.
  function automatic logic [31:0] pack_status(
    input logic [3:0] cnt,
    input logic       ovf,
    input logic       full,
    input logic       empty
  );
    logic [31:0] v;
    v = '0;
    v[c_ST_COUNT_LSB +: 4] = cnt;
    v[c_ST_OVF]            = ovf;
    v[c_ST_FULL]           = full;
    v[c_ST_EMPTY]          = empty;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_dbus_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_dbus_fifo                                               |
// | Description : Parameterised synchronous FIFO with extra-bit pointers.      |
// |               A push is taken when not full, or when a pop happens in the  |
// |               same cycle, so full + push + pop keeps the count at DEPTH.   |
// | Ports       : i_clk, i_rst_n (sync, active-low), i_push/i_din,            |
// |               i_pop/o_dout (head, combinational), o_empty, o_full,         |
// |               o_count (0..DEPTH), o_push_ok (push accepted this cycle).    |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_dbus_fifo #(
  parameter int DEPTH = 8,
  parameter int DW    = 8
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [DW-1:0]              i_din,
  input  logic                       i_pop,
  output logic [DW-1:0]              o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_push_ok
);

  localparam int c_AW = $clog2(DEPTH);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [c_AW:0] r_wptr;
  logic [c_AW:0] r_rptr;

  logic          w_pop_ok;

  assign o_count = r_wptr - r_rptr;
  assign o_empty = (r_wptr == r_rptr);
  // Full when the wrap bits differ but the index bits match.
  assign o_full  = (r_wptr[c_AW] != r_rptr[c_AW]) &&
                   (r_wptr[c_AW-1:0] == r_rptr[c_AW-1:0]);
  assign o_dout  = r_mem[r_rptr[c_AW-1:0]];

  assign w_pop_ok  = i_pop & ~o_empty;
  // A same-cycle pop frees the slot the push is about to use.
  assign o_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (o_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop_ok)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define validity.
  always_ff @(posedge i_clk) begin
    if (o_push_ok) r_mem[r_wptr[c_AW-1:0]] <= i_din;
  end

endmodule
`default_nettype wire

// File: rtl/mips_dbus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mips_dbus                                                    |
// | Description : Data-side bus target for mips_core's MEM stage. Every access |
// |               completes in the cycle it is presented; DI is combinational. |
// |               Decodes to a byte-lane RAM (aliased across non-I/O space) or |
// |               an I/O window holding TXDATA, STATUS, CYCLE and a reserved   |
// |               slot. The CYCLE counter exists only when the macro           |
// |               MIPS_DBUS_CYCLE_EN is defined; otherwise CYCLE reads 0.      |
// | Ports       : clock, reset (sync, active-low), DA/we/DO/re from the core,  |
// |               DI read data, tx_data/tx_valid/tx_ready UART TX handshake.   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mips_dbus
  import mips_dbus_pkg::*;
#(
  parameter int          RAM_AW     = 12,
  parameter logic [31:0] IO_BASE    = 32'hFFFF0000,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] DA,
  input  logic [3:0]  we,
  input  logic [31:0] DO,
  input  logic        re,
  output logic [31:0] DI,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int c_FAW = $clog2(FIFO_DEPTH);

  // ---------------------------------------------------------------- decode
  logic              w_io;
  io_reg_e           w_reg;
  logic [RAM_AW-1:0] w_ram_idx;

  assign w_io      = (DA[31:16] == IO_BASE[31:16]);
  assign w_reg     = io_reg_e'(DA[3:2]);
  assign w_ram_idx = DA[RAM_AW+1:2];

  // Strobe and the unused address bits carry no function here.
  logic w_unused;
  assign w_unused = ^{re, DA};

  // ------------------------------------------------------------------- RAM
  logic [31:0] r_ram [0:(2**RAM_AW)-1];

  always_ff @(posedge clock) begin
    if (!w_io) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) r_ram[w_ram_idx][8*i +: 8] <= DO[8*i +: 8];
      end
    end
  end

  // --------------------------------------------------------------- TX FIFO
  logic             w_push;
  logic             w_pop;
  logic             w_push_ok;
  logic             w_empty;
  logic             w_full;
  logic [c_FAW:0]   w_count;

  assign w_push = w_io && (w_reg == IO_TXDATA) && we[0];
  assign w_pop  = tx_valid & tx_ready;

  mips_dbus_fifo #(
    .DEPTH (FIFO_DEPTH),
    .DW    (8)
  ) u_fifo (
    .i_clk     (clock),
    .i_rst_n   (reset),
    .i_push    (w_push),
    .i_din     (DO[7:0]),
    .i_pop     (w_pop),
    .o_dout    (tx_data),
    .o_empty   (w_empty),
    .o_full    (w_full),
    .o_count   (w_count),
    .o_push_ok (w_push_ok)
  );

  assign tx_valid = ~w_empty;

  // ------------------------------------------------------------ ovf sticky
  logic r_ovf;
  logic w_ovf_set;
  logic w_ovf_clr;

  assign w_ovf_set = w_push & ~w_push_ok;
  assign w_ovf_clr = w_io && (w_reg == IO_STATUS) && we[0] && DO[c_ST_OVF];

  // Set has priority over the write-1-to-clear.
  always_ff @(posedge clock) begin
    if (!reset)         r_ovf <= 1'b0;
    else if (w_ovf_set) r_ovf <= 1'b1;
    else if (w_ovf_clr) r_ovf <= 1'b0;
  end

  // ---------------------------------------------------------- cycle counter
  logic [31:0] w_cycle_rd;

`ifdef MIPS_DBUS_CYCLE_EN
  logic [31:0] r_cycle;
  logic        w_cycle_ld;

  // Only a full-word write loads; partial-lane writes are dropped.
  assign w_cycle_ld = w_io && (w_reg == IO_CYCLE) && (we == 4'hF);

  always_ff @(posedge clock) begin
    if (!reset)          r_cycle <= '0;
    else if (w_cycle_ld) r_cycle <= DO;
    else                 r_cycle <= r_cycle + 32'd1;
  end

  assign w_cycle_rd = r_cycle;
`else
  assign w_cycle_rd = '0;
`endif

  // ---------------------------------------------------------------- DI mux
  always_comb begin
    DI = '0;
    if (w_io) begin
      case (w_reg)
        IO_STATUS: DI = pack_status(4'(w_count), r_ovf, w_full, w_empty);
        IO_CYCLE:  DI = w_cycle_rd;
        default:   DI = '0;
      endcase
    end else begin
      DI = r_ram[w_ram_idx];
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_dbus.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mips_dbus                                                 |
// | Description : Directed self-checking bench for mips_dbus: RAM lanes and    |
// |               aliasing, FIFO fill/overflow/W1C/drain, simultaneous push    |
// |               and pop, push latency, reset mid-operation and the CYCLE     |
// |               register (both builds of MIPS_DBUS_CYCLE_EN).                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mips_dbus;

  localparam int          c_RAM_AW  = 12;
  localparam logic [31:0] c_IO      = 32'hFFFF0000;
  localparam logic [31:0] c_TXDATA  = c_IO | 32'h0;
  localparam logic [31:0] c_STATUS  = c_IO | 32'h4;
  localparam logic [31:0] c_CYCLE   = c_IO | 32'h8;
  localparam logic [31:0] c_RSVD    = c_IO | 32'hC;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] DA    = '0;
  logic [3:0]  we    = '0;
  logic [31:0] DO    = '0;
  logic        re    = 1'b0;
  logic [31:0] DI;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  mips_dbus #(
    .RAM_AW     (c_RAM_AW),
    .IO_BASE    (c_IO),
    .FIFO_DEPTH (8)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .DA       (DA),
    .we       (we),
    .DO       (DO),
    .re       (re),
    .DI       (DI),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    DA = c_TXDATA; we = 4'b0001; DO = {24'h0, b};
    tick();
    we = 4'b0000;
  endtask

  task automatic rd(input logic [31:0] a);
    DA = a; we = 4'b0000;
    #1;
  endtask

  initial begin
    // Reset
    tick(); tick();
    reset = 1'b1;
    rd(c_STATUS);
    check("reset_status", DI, 32'h01);
    check("reset_tx_valid", {31'b0, tx_valid}, 32'h0);

    // 1. RAM lanes and aliasing
    DA = 32'h100; we = 4'hF; DO = 32'h11223344; tick();
    we = 4'b0100; DO = 32'h00AA0000; tick();
    rd(32'h100);
    check("ram_lane", DI, 32'h11AA3344);
    rd(32'h100 + (32'd4 << c_RAM_AW));
    check("ram_alias", DI, 32'h11AA3344);
    DA = 32'h100; we = 4'hF; DO = 32'hDEADBEEF; #1;
    check("ram_prewrite", DI, 32'h11AA3344);
    tick();
    rd(32'h100);
    check("ram_written", DI, 32'hDEADBEEF);

    // 2. FIFO fill with tx_ready=0
    tx_ready = 1'b0;
    for (int i = 0; i < 8; i++) push(8'h41 + 8'(i));
    rd(c_STATUS);
    check("fill_status", DI, 32'h82);
    check("fill_head", {24'h0, tx_data}, 32'h41);
    push(8'h49);
    rd(c_STATUS);
    check("ovf_status", DI, 32'h86);
    check("ovf_head", {24'h0, tx_data}, 32'h41);
    DA = c_STATUS; we = 4'b0001; DO = 32'h4; tick();
    rd(c_STATUS);
    check("w1c_status", DI, 32'h82);

    // 3. Drain with tx_ready=1
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check("drain_valid", {31'b0, tx_valid}, 32'h1);
      check("drain_data", {24'h0, tx_data}, 32'h41 + i);
      tick();
    end
    tx_ready = 1'b0;
    rd(c_STATUS);
    check("drain_empty_valid", {31'b0, tx_valid}, 32'h0);
    check("drain_status", DI, 32'h01);

    // 4a. Full FIFO, push and pop together
    for (int i = 0; i < 8; i++) push(8'h61 + 8'(i));
    DA = c_TXDATA; we = 4'b0001; DO = 32'h55; tx_ready = 1'b1;
    tick();
    we = 4'b0000; tx_ready = 1'b0;
    rd(c_STATUS);
    check("pushpop_status", DI, 32'h82);
    tx_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      check("pushpop_data", {24'h0, tx_data}, 32'h62 + i);
      tick();
    end
    check("pushpop_last", {24'h0, tx_data}, 32'h55);
    tick();
    tx_ready = 1'b0;
    check("pushpop_empty", {31'b0, tx_valid}, 32'h0);

    // 4b. Push latency into empty FIFO
    DA = c_TXDATA; we = 4'b0001; DO = 32'h77; #1;
    check("latency_same_cycle", {31'b0, tx_valid}, 32'h0);
    tick();
    we = 4'b0000;
    check("latency_next_cycle", {31'b0, tx_valid}, 32'h1);
    check("latency_data", {24'h0, tx_data}, 32'h77);

    // 5. Reset mid-operation
    push(8'h78); push(8'h79);
    rd(c_STATUS);
    check("pre_reset_status", DI, 32'h30);
    reset = 1'b0; tick(); reset = 1'b1;
    rd(c_STATUS);
    check("mid_reset_valid", {31'b0, tx_valid}, 32'h0);
    check("mid_reset_status", DI, 32'h01);
    rd(32'h100);
    check("reset_ram_kept", DI, 32'hDEADBEEF);
    // ovf also clears on reset
    for (int i = 0; i < 9; i++) push(8'h80 + 8'(i));
    rd(c_STATUS);
    check("ovf_before_reset", DI, 32'h86);
    reset = 1'b0; tick(); reset = 1'b1;
    rd(c_STATUS);
    check("ovf_after_reset", DI, 32'h01);

    // Other I/O reads
    rd(c_TXDATA);
    check("txdata_reads_0", DI, 32'h0);
    DA = c_RSVD; we = 4'hF; DO = 32'hFFFFFFFF; tick();
    rd(c_RSVD);
    check("rsvd_reads_0", DI, 32'h0);

    // 6. CYCLE register
`ifdef MIPS_DBUS_CYCLE_EN
    DA = c_CYCLE; we = 4'hF; DO = 32'hFFFFFFFE; tick();
    we = 4'b0000; #1;
    check("cycle_load", DI, 32'hFFFFFFFE);
    tick();
    check("cycle_ffff", DI, 32'hFFFFFFFF);
    tick();
    check("cycle_wrap", DI, 32'h0);
    we = 4'b0011; DO = 32'h12345678; tick();
    we = 4'b0000; #1;
    check("cycle_partial_ignored", DI, 32'h1);
`else
    DA = c_CYCLE; we = 4'hF; DO = 32'hFFFFFFFE; tick();
    we = 4'b0000; #1;
    check("cycle_off_a", DI, 32'h0);
    tick();
    check("cycle_off_b", DI, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
